// File: rtl/rggen_axi4lite_initiator.sv
// AXI4-Lite initiator bridge: one rggen bus request -> one AXI4-Lite read or write transaction.
// Optional: define RGGEN_AXI4LITE_INITIATOR_ID_CHECK_EN to turn bid/rid mismatches into SLVERR.
module rggen_axi4lite_initiator #(
  parameter int          ID_WIDTH      = 0,
  parameter int          ADDRESS_WIDTH = 8,
  parameter int          BUS_WIDTH     = 32,
  parameter int          AXI_ID        = 0,
  parameter logic [2:0]  AXI_PROT      = 3'b000,
  localparam int         IDW           = (ID_WIDTH > 0) ? ID_WIDTH : 1,
  localparam int         SW            = BUS_WIDTH / 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_bus_valid,
  input  logic [1:0]               i_bus_access,
  input  logic [ADDRESS_WIDTH-1:0] i_bus_address,
  input  logic [BUS_WIDTH-1:0]     i_bus_write_data,
  input  logic [SW-1:0]            i_bus_strobe,
  output logic                     o_bus_ready,
  output logic [1:0]               o_bus_status,
  output logic [BUS_WIDTH-1:0]     o_bus_read_data,
  output logic                     o_awvalid,
  input  logic                     i_awready,
  output logic [IDW-1:0]           o_awid,
  output logic [ADDRESS_WIDTH-1:0] o_awaddr,
  output logic [2:0]               o_awprot,
  output logic                     o_wvalid,
  input  logic                     i_wready,
  output logic [BUS_WIDTH-1:0]     o_wdata,
  output logic [SW-1:0]            o_wstrb,
  input  logic                     i_bvalid,
  output logic                     o_bready,
  input  logic [IDW-1:0]           i_bid,
  input  logic [1:0]               i_bresp,
  output logic                     o_arvalid,
  input  logic                     i_arready,
  output logic [IDW-1:0]           o_arid,
  output logic [ADDRESS_WIDTH-1:0] o_araddr,
  output logic [2:0]               o_arprot,
  input  logic                     i_rvalid,
  output logic                     o_rready,
  input  logic [IDW-1:0]           i_rid,
  input  logic [1:0]               i_rresp,
  input  logic [BUS_WIDTH-1:0]     i_rdata
);

  localparam logic [IDW-1:0] ID_VAL = (ID_WIDTH == 0) ? '0 : IDW'(AXI_ID);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_e;

  state_e                   state, state_n;
  logic                     awvalid_n, wvalid_n, arvalid_n, bready_n, rready_n, bus_ready_n;
  logic [1:0]               status_n;
  logic [BUS_WIDTH-1:0]     rdata_n;
  logic                     capture;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [BUS_WIDTH-1:0]     wdata_q;
  logic [SW-1:0]            strb_q;
  logic                     bid_ok, rid_ok;

`ifdef RGGEN_AXI4LITE_INITIATOR_ID_CHECK_EN
  assign bid_ok = (ID_WIDTH == 0) || (i_bid == ID_VAL);
  assign rid_ok = (ID_WIDTH == 0) || (i_rid == ID_VAL);
`else
  logic unused_id;
  assign unused_id = ^{i_bid, i_rid};
  assign bid_ok    = 1'b1;
  assign rid_ok    = 1'b1;
`endif

  assign o_awid   = ID_VAL;
  assign o_arid   = ID_VAL;
  assign o_awprot = AXI_PROT;
  assign o_arprot = AXI_PROT;
  assign o_awaddr = addr_q;
  assign o_araddr = addr_q;
  assign o_wdata  = wdata_q;
  assign o_wstrb  = strb_q;

  always_comb begin
    state_n     = state;
    awvalid_n   = o_awvalid;
    wvalid_n    = o_wvalid;
    arvalid_n   = o_arvalid;
    bready_n    = o_bready;
    rready_n    = o_rready;
    bus_ready_n = 1'b0;
    status_n    = o_bus_status;
    rdata_n     = o_bus_read_data;
    capture     = 1'b0;
    case (state)
      IDLE: if (i_bus_valid) begin
        capture = 1'b1;
        if (i_bus_access[0]) begin
          state_n   = WR_REQ;
          awvalid_n = 1'b1;
          wvalid_n  = 1'b1;
        end else begin
          state_n   = RD_REQ;
          arvalid_n = 1'b1;
        end
      end
      // AW and W complete independently; bready rises on the edge the later one finishes
      WR_REQ: begin
        awvalid_n = o_awvalid & ~i_awready;
        wvalid_n  = o_wvalid & ~i_wready;
        if (!awvalid_n && !wvalid_n) begin
          state_n  = WR_RESP;
          bready_n = 1'b1;
        end
      end
      WR_RESP: if (i_bvalid) begin
        state_n     = DONE;
        bready_n    = 1'b0;
        bus_ready_n = 1'b1;
        status_n    = bid_ok ? i_bresp : 2'b10;
        rdata_n     = '0;
      end
      RD_REQ: if (i_arready) begin
        state_n   = RD_RESP;
        arvalid_n = 1'b0;
        rready_n  = 1'b1;
      end
      RD_RESP: if (i_rvalid) begin
        state_n     = DONE;
        rready_n    = 1'b0;
        bus_ready_n = 1'b1;
        status_n    = rid_ok ? i_rresp : 2'b10;
        rdata_n     = rid_ok ? i_rdata : '0;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      o_awvalid       <= 1'b0;
      o_wvalid        <= 1'b0;
      o_arvalid       <= 1'b0;
      o_bready        <= 1'b0;
      o_rready        <= 1'b0;
      o_bus_ready     <= 1'b0;
      o_bus_status    <= 2'b00;
      o_bus_read_data <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
      strb_q          <= '0;
    end else begin
      state           <= state_n;
      o_awvalid       <= awvalid_n;
      o_wvalid        <= wvalid_n;
      o_arvalid       <= arvalid_n;
      o_bready        <= bready_n;
      o_rready        <= rready_n;
      o_bus_ready     <= bus_ready_n;
      o_bus_status    <= status_n;
      o_bus_read_data <= rdata_n;
      if (capture) begin
        addr_q  <= i_bus_address;
        wdata_q <= i_bus_write_data;
        strb_q  <= i_bus_strobe;
      end
    end
  end

endmodule
